// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - encodings, state type and beat-count helper for lsu_align
package lsu_pkg;

  localparam logic [2:0] RD_IDLE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LBU  = 3'b010;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SB   = 2'b01;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SW   = 2'b11;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  // 1 for a natively aligned access, byte count when it must be split, 0 for illegal size.
  function automatic logic [2:0] beats_for(input logic [1:0] size, input logic [1:0] addr);
    logic [2:0] n;
    case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = addr[0] ? 3'd2 : 3'd1;
      SZ_WORD: n = (addr != 2'b00) ? 3'd4 : 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - sign/zero extension of an assembled load value by access size
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = data_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{~unsigned_i & data_i[7]}}, data_i[7:0]};
      SZ_HALF: data_o = {{16{~unsigned_i & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment unit splitting misaligned accesses into byte beats
module lsu_align
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [2:0]  dm_rd_ctrl,
  output logic [1:0]  dm_wr_ctrl,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  input  logic [31:0] dm_dout
);

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  beats_q, beats_d;
  logic [1:0]  beat_q, beat_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        aligned;
  logic        last_beat;
  logic [31:0] beat_data;
  logic [31:0] ext_data;

  assign aligned   = (beats_q == 3'd1);
  assign last_beat = ({1'b0, beat_q} == (beats_q - 3'd1));

  // Value as it will look once this beat's byte lands; aligned beats take the whole word.
  always_comb begin
    beat_data = asm_q;
    beat_data[{beat_q, 3'b000} +: 8] = dm_dout[7:0];
    if (aligned) begin
      beat_data = dm_dout;
    end
  end

  lsu_extend u_extend (
    .data_i     (beat_data),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext_data)
  );

  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    beats_d = beats_q;
    beat_d  = beat_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          beats_d = beats_for(req_size, req_addr[1:0]);
          beat_d  = 2'd0;
          asm_d   = 32'd0;
          if (req_size == SZ_ILL) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (!store_q) begin
          asm_d = beat_data;
        end
        if (last_beat) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          rdata_d = store_q ? 32'd0 : ext_data;
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dm_rd_ctrl = RD_IDLE;
    dm_wr_ctrl = WR_NONE;
    dm_addr    = 32'd0;
    dm_din     = 32'd0;
    if (state_q == ST_ACCESS) begin
      dm_addr = addr_q + {30'd0, beat_q};
      if (store_q) begin
        if (aligned) begin
          dm_wr_ctrl = (size_q == SZ_BYTE) ? WR_SB : (size_q == SZ_HALF) ? WR_SH : WR_SW;
          dm_din     = wdata_q << {addr_q[1:0], 3'b000};
        end else begin
          dm_wr_ctrl = WR_SB;
          dm_din     = {4{wdata_q[{beat_q, 3'b000} +: 8]}};
        end
      end else begin
        if (aligned) begin
          dm_rd_ctrl = (size_q == SZ_BYTE) ? RD_LBU : (size_q == SZ_HALF) ? RD_LHU : RD_LW;
        end else begin
          dm_rd_ctrl = RD_LBU;
        end
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_DONE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      store_q <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      beats_q <= 3'd0;
      beat_q  <= 2'd0;
      asm_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beats_q <= beats_d;
      beat_q  <= beat_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - randomized self-checking bench for lsu_align against a byte-level reference
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [2:0]  dm_rd_ctrl;
  logic [1:0]  dm_wr_ctrl;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  logic [7:0]  mem [0:4095];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  lsu_align dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dm_rd_ctrl   (dm_rd_ctrl),
    .dm_wr_ctrl   (dm_wr_ctrl),
    .dm_addr      (dm_addr),
    .dm_din       (dm_din),
    .dm_dout      (dm_dout)
  );

  // Memory is 4 KiB aliased over the full address space; reads are combinational.
  logic [11:0] ma;
  assign ma = dm_addr[11:0];
  always_comb begin
    dm_dout = 32'd0;
    case (dm_rd_ctrl)
      3'b001: dm_dout = {{24{mem[ma][7]}}, mem[ma]};
      3'b010: dm_dout = {24'd0, mem[ma]};
      3'b011: dm_dout = {{16{mem[ma+12'd1][7]}}, mem[ma+12'd1], mem[ma]};
      3'b100: dm_dout = {16'd0, mem[ma+12'd1], mem[ma]};
      3'b101: dm_dout = {mem[ma+12'd3], mem[ma+12'd2], mem[ma+12'd1], mem[ma]};
      default: dm_dout = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Commit any write the memory sees this cycle, then advance one clock.
  task automatic step();
    logic [11:0] a;
    a = dm_addr[11:0];
    case (dm_wr_ctrl)
      2'b01: mem[a] = dm_din[8*a[1:0] +: 8];
      2'b10: begin
        mem[a]        = dm_din[8*a[1:0] +: 8];
        mem[a+12'd1]  = dm_din[8*a[1:0]+8 +: 8];
      end
      2'b11: for (int i = 0; i < 4; i++) mem[a + 12'(i)] = dm_din[8*i +: 8];
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic noise();
    req_valid    = 1'($urandom);
    req_store    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd);
    int unsigned nb, n, off;
    logic [31:0] val, exp_rd, exp_din;
    logic [2:0]  exp_rd_ctrl;
    logic [1:0]  exp_wr_ctrl;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = ad[1:0];
    if (sz == 2'd3) n = 0;
    else if (off % nb == 0) n = 1;
    else n = nb;
    val = 32'd0;
    for (int unsigned i = 0; i < nb; i++) val[8*i +: 8] = mem[12'(ad + i)];
    if (!un && nb == 1) val = {{24{val[7]}}, val[7:0]};
    if (!un && nb == 2) val = {{16{val[15]}}, val[15:0]};
    exp_rd = (st || sz == 2'd3) ? 32'd0 : val;

    check("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = ad; req_wdata = wd;
    step();
    for (int unsigned c = 0; c < n; c++) begin
      noise();
      if (n == 1) begin
        exp_rd_ctrl = st ? 3'b000 : (nb == 1) ? 3'b010 : (nb == 2) ? 3'b100 : 3'b101;
        exp_wr_ctrl = !st ? 2'b00 : (nb == 1) ? 2'b01 : (nb == 2) ? 2'b10 : 2'b11;
        exp_din     = wd << (8 * off);
      end else begin
        exp_rd_ctrl = st ? 3'b000 : 3'b010;
        exp_wr_ctrl = st ? 2'b01 : 2'b00;
        exp_din     = {4{wd[8*c +: 8]}};
      end
      check("busy_resp_valid", 32'(resp_valid), 32'd0);
      check("beat_addr", dm_addr, ad + c);
      check("beat_rd_ctrl", 32'(dm_rd_ctrl), 32'(exp_rd_ctrl));
      check("beat_wr_ctrl", 32'(dm_wr_ctrl), 32'(exp_wr_ctrl));
      if (st) check("beat_din", dm_din, exp_din);
      step();
    end
    noise();
    check("done_resp_valid", 32'(resp_valid), 32'd1);
    check("done_resp_err", 32'(resp_err), (sz == 2'd3) ? 32'd1 : 32'd0);
    check("done_resp_rdata", resp_rdata, exp_rd);
    check("done_dm_idle", {dm_addr[27:0], 1'b0, dm_rd_ctrl} | dm_din | 32'(dm_wr_ctrl), 32'd0);
    check("done_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = 1'b0;
    check("after_resp_valid", 32'(resp_valid), 32'd0);
    check("after_rdata_hold", resp_rdata, exp_rd);
    if (st && sz != 2'd3)
      for (int unsigned i = 0; i < nb; i++)
        check("store_byte", 32'(mem[12'(ad + i)]), 32'(wd[8*i +: 8]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    step();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_dm", dm_addr | dm_din | 32'(dm_rd_ctrl) | 32'(dm_wr_ctrl), 32'd0);
    rst = 1'b0;
    step();

    mem[12'h100] = 8'h21; mem[12'h101] = 8'h43; mem[12'h102] = 8'h65; mem[12'h103] = 8'h87;
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    check("lw_0x100", resp_rdata, 32'h8765_4321);
    mem[12'h103] = 8'h80;
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'd0);
    check("lb_signed", resp_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'd0);
    check("lbu", resp_rdata, 32'h0000_0080);
    do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_BEEF);
    check("sh_low_unchanged", {mem[12'h101], mem[12'h100]}, 32'h4321);
    check("sh_high", {mem[12'h103], mem[12'h102]}, 32'hBEEF);
    do_req(1'b1, 2'd2, 1'b0, 32'h201, 32'h1122_3344);
    mem[12'h303] = 8'h34; mem[12'h304] = 8'h92;
    do_req(1'b0, 2'd1, 1'b0, 32'h303, 32'd0);
    check("lh_misaligned", resp_rdata, 32'hFFFF_9234);
    do_req(1'b0, 2'd2, 1'b1, 32'hFFFF_FFFF, 32'd0);
    do_req(1'b0, 2'd3, 1'b0, 32'h400, 32'd0);

    for (int i = 0; i < 4; i++) mem[12'h201 + 12'(i)] = 8'h00;
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h201; req_wdata = 32'h1122_3344;
    step();
    req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_wr_ctrl", 32'(dm_wr_ctrl), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_mid_quiet", 32'(resp_valid) | 32'(dm_wr_ctrl), 32'd0);
    end
    check("rst_mid_b0", 32'(mem[12'h201]), 32'h44);
    check("rst_mid_b1", 32'(mem[12'h202]), 32'h33);
    check("rst_mid_b2", 32'(mem[12'h203]), 32'h00);

    for (int i = 0; i < 120; i++) begin
      logic [31:0] ad;
      ad = (i % 4 == 0) ? $urandom : 32'($urandom_range(0, 4095));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), ad, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
